// File: rtl/alu_pkg.sv
// Shared definitions for the mini ALU and its downstream stages.
//   - ALU opcode encodings (ALU_ILLEGAL is the ALU default case, which yields a zero sum)
//   - default datapath / opcode widths
//   - packed result entry {result, oper, zero, neg, illegal}
package alu_pkg;

  localparam int unsigned ALU_DATA_W = 64;
  localparam int unsigned ALU_OPER_W = 3;

  localparam logic [ALU_OPER_W-1:0] ALU_ADD     = 3'b000;
  localparam logic [ALU_OPER_W-1:0] ALU_SUB     = 3'b001;
  localparam logic [ALU_OPER_W-1:0] ALU_RSUB    = 3'b010;
  localparam logic [ALU_OPER_W-1:0] ALU_OR      = 3'b011;
  localparam logic [ALU_OPER_W-1:0] ALU_AND     = 3'b100;
  localparam logic [ALU_OPER_W-1:0] ALU_XOR     = 3'b101;
  localparam logic [ALU_OPER_W-1:0] ALU_XNOR    = 3'b110;
  localparam logic [ALU_OPER_W-1:0] ALU_ILLEGAL = 3'b111;

  typedef struct packed {
    logic [ALU_DATA_W-1:0] result;
    logic [ALU_OPER_W-1:0] oper;
    logic                  zero;
    logic                  neg;
    logic                  illegal;
  } alu_entry_t;

endpackage

// File: rtl/alu_flag_gen.sv
// Combinational status-flag decode for an ALU result.
// Ports:
//   sum     in   DATA_W  ALU sum
//   oper    in   OPER_W  opcode that produced sum
//   zero    out  1       sum == 0
//   neg     out  1       sum[DATA_W-1]
//   illegal out  1       oper is the illegal / default opcode
module alu_flag_gen
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = ALU_DATA_W,
  parameter int unsigned OPER_W = ALU_OPER_W
) (
  input  logic [DATA_W-1:0] sum,
  input  logic [OPER_W-1:0] oper,
  output logic              zero,
  output logic              neg,
  output logic              illegal
);

  assign zero    = (sum == '0);
  assign neg     = sum[DATA_W-1];
  assign illegal = (oper == OPER_W'(ALU_ILLEGAL));

endmodule

// File: rtl/alu_result_stage.sv
// Registered output stage behind the mini ALU. Captures sum + opcode with precomputed
// flags into a 2-entry skid buffer and presents them over valid/ready. in_ready is a
// flop output so no combinational ready path reaches back into the ALU issue logic.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   in_valid/in_ready upstream handshake (in_ready registered)
//   sum_in, oper_in   ALU sum and its opcode
//   out_valid/out_ready downstream handshake
//   out_result, out_oper, out_zero, out_neg, out_illegal  head entry fields
//   retired_cnt       completed output handshakes, wraps modulo 2^CNT_W
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = ALU_DATA_W,
  parameter int unsigned OPER_W = ALU_OPER_W,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] sum_in,
  input  logic [OPER_W-1:0] oper_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [OPER_W-1:0] out_oper,
  output logic              out_zero,
  output logic              out_neg,
  output logic              out_illegal,
  output logic [CNT_W-1:0]  retired_cnt
);

  // Entry storage uses the shared packed type, so widths must agree with the package.
  if (DATA_W != ALU_DATA_W || OPER_W != ALU_OPER_W) begin : g_bad_cfg
    $error("alu_result_stage: DATA_W/OPER_W must match alu_pkg");
  end

  typedef enum logic [1:0] {StEmpty, StOne, StFull} occ_e;

  occ_e       state_q, state_d;
  alu_entry_t main_q, main_d;
  alu_entry_t skid_q, skid_d;
  alu_entry_t new_entry;
  logic       in_ready_q, in_ready_d;
  logic       out_valid_q, out_valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic       accept, retire;
  logic       new_zero, new_neg, new_illegal;

  alu_flag_gen #(
    .DATA_W (DATA_W),
    .OPER_W (OPER_W)
  ) u_flag_gen (
    .sum     (sum_in),
    .oper    (oper_in),
    .zero    (new_zero),
    .neg     (new_neg),
    .illegal (new_illegal)
  );

  always_comb begin
    new_entry         = '0;
    new_entry.result  = sum_in;
    new_entry.oper    = oper_in;
    new_entry.zero    = new_zero;
    new_entry.neg     = new_neg;
    new_entry.illegal = new_illegal;
  end

  assign accept = in_valid & in_ready_q;
  assign retire = out_valid_q & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    cnt_d   = retire ? cnt_q + CNT_W'(1) : cnt_q;
    unique case (state_q)
      StEmpty: begin
        if (accept) begin
          main_d  = new_entry;
          state_d = StOne;
        end
      end
      StOne: begin
        if (accept && retire) begin
          main_d = new_entry;
        end else if (accept) begin
          skid_d  = new_entry;
          state_d = StFull;
        end else if (retire) begin
          state_d = StEmpty;
        end
      end
      StFull: begin
        // in_ready_q is low here, so accept cannot fire.
        if (retire) begin
          main_d  = skid_q;
          state_d = StOne;
        end
      end
      default: state_d = StEmpty;
    endcase
    // Handshake outputs are decoded from the next state so they leave flops directly.
    in_ready_d  = (state_d != StFull);
    out_valid_d = (state_d != StEmpty);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StEmpty;
      main_q      <= '0;
      skid_q      <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_result  = main_q.result;
  assign out_oper    = main_q.oper;
  assign out_zero    = main_q.zero;
  assign out_neg     = main_q.neg;
  assign out_illegal = main_q.illegal;
  assign retired_cnt = cnt_q;

endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
- Registered output stage directly downstream of the 64-bit mini ALU.
- Captures the combinational ALU sum together with the opcode that produced it, and derives status flags (zero, negative, illegal-op).
- Presents the result to the consumer over a valid/ready handshake.
- A 2-entry skid buffer keeps in_ready a pure register output, so no combinational ready path reaches back into the ALU issue logic.

Parameters:
- DATA_W, 64: result width; must match the ALU sum width.
- OPER_W, 3: opcode width.
- CNT_W, 16: width of the retired-result counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  ALU result on sum_in/oper_in is valid this cycle.
- in_ready  output  1  stage can accept; driven directly from a flop.
- sum_in  input  DATA_W  ALU sum.
- oper_in  input  OPER_W  opcode that produced sum_in.
- out_valid  output  1  out_* fields hold a valid result.
- out_ready  input  1  consumer accepts this cycle.
- out_result  output  DATA_W  registered result.
- out_oper  output  OPER_W  registered opcode.
- out_zero  output  1  out_result == 0.
- out_neg  output  1  out_result[DATA_W-1].
- out_illegal  output  1  out_oper == 3'b111, the ALU default case; result is 0.
- retired_cnt  output  CNT_W  count of completed output handshakes; wraps modulo 2^CNT_W.

Behaviour:
- Handshake and storage
  - Accept when in_valid & in_ready. Retire when out_valid & out_ready.
  - Storage is two entries: a main register (drives out_*) and a skid register. Each entry holds {result, oper, zero, neg, illegal}.
  - Flags are computed from sum_in/oper_in before capture. No flag logic sits on the output path.
- State machine (count of occupied entries)
  - EMPTY: out_valid=0, in_ready=1.
    - Accept -> load main, go ONE. Latency in to out is 1 cycle.
  - ONE: out_valid=1, in_ready=1.
    - Accept & retire -> load main with new data, stay ONE.
    - Accept & !retire -> load skid, go FULL.
    - !accept & retire -> go EMPTY.
    - Neither -> hold.
  - FULL: out_valid=1, in_ready=0.
    - Retire -> skid moves to main, go ONE.
    - Otherwise hold.
    - in_valid is ignored; no accept is possible.
- Output stability and ordering
  - While out_valid=1 and out_ready=0, all out_* fields hold stable.
  - Ordering is strictly FIFO. No entry is dropped or duplicated.
- Flags and counter
  - out_illegal is pure opcode decode. out_zero is also set for that entry whenever sum_in == 0.
  - retired_cnt increments by 1 on each retire. It wraps from 2^CNT_W-1 to 0.
- Reset
  - Reset wins over every other event in the same cycle.
  - All data registers and retired_cnt clear to 0. State goes to EMPTY, out_valid=0, in_ready=1.
  - Reset mid-operation discards both entries without retiring them.
- Idle behaviour: in_valid=0 never changes state or data, except for retire transitions.

Decomposition:
- Shared package alu_pkg holds:
  - localparams ALU_ADD=3'b000, ALU_SUB=3'b001, ALU_RSUB=3'b010, ALU_OR=3'b011, ALU_AND=3'b100, ALU_XOR=3'b101, ALU_XNOR=3'b110, ALU_ILLEGAL=3'b111;
  - DATA_W default;
  - a packed result-entry typedef {result, oper, zero, neg, illegal}.
- The occupancy encoding EMPTY/ONE/FULL stays local.
- One natural sub-module, alu_flag_gen: purely combinational zero/neg/illegal from sum and oper. It is reusable by the ALU issue stage.
- The skid logic stays inline.

Test Plan:
- Reset then idle: rst=1 for 2 cycles with in_valid=1 -> out_valid=0, in_ready=1, retired_cnt=0, nothing captured.
- Single pass: in sum_in=64'h0000_0000_0000_0005, oper=000, out_ready=1 -> next cycle out_valid=1, out_result=5, zero=0, neg=0, illegal=0; after retire retired_cnt=1.
- Backpressure: out_ready=0, send 3 back-to-back results A=1, B=64'h8000_0000_0000_0000, C=2 -> A in main, B in skid, in_ready=0 next cycle, C held upstream. Raise out_ready -> out order A, B (neg=1), C, no loss.
- Full throughput: out_ready=1, in_valid=1 for 100 cycles with incrementing sums -> one result per cycle, in_ready constantly 1, retired_cnt=100.
- Flags: sum 0 with oper 100 -> zero=1. Sum 0 with oper 111 -> zero=1, illegal=1. Sum 64'hFFFF_FFFF_FFFF_FFFF with oper 110 -> neg=1.
- Reset in FULL plus wrap: fill both entries, assert rst with out_ready=1 -> next cycle EMPTY, out_valid=0, retired_cnt=0. Preload CNT_W=4 build, retire 16 results -> retired_cnt wraps to 0.
